c1541_gcr_track_loader: RTL

//  Upstream feeder for the direct-GCR head/track buffer. Tracks the stepper half-track and

---
 rtl/c1541_gcr_track_loader.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/c1541_gcr_track_loader.sv
// Feeds the GCR track buffer from SD: follows the head's half-track, writes back a
// dirty track, then loads the new track's raw GCR image block by block.
module c1541_gcr_track_loader #(
    parameter int TRACK_BLOCKS = 16,
    parameter int MAX_HTRACK   = 84,
    parameter int SETTLE_TICKS = 12000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic [6:0]  htrack,
    input  logic        mtr,
    input  logic        gcr_we,
    output logic        busy,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    output logic [3:0]  sd_blk
);

    localparam int CNT_W = $clog2(SETTLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_TICKS - 1);
    localparam logic [3:0]       LAST_BLK = 4'(TRACK_BLOCKS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_WB_REQ, S_WB_XFER, S_RD_REQ, S_RD_XFER
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       cur_ht_q, cur_ht_d;
    logic [6:0]       htrack_l_q, htrack_l_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       blk_q, blk_d;
    logic             dirty_q, dirty_d;
    logic             loaded_q, loaded_d;
    logic             busy_q, busy_d;
    logic             sd_rd_q, sd_rd_d;
    logic             sd_wr_q, sd_wr_d;
    logic             flush_q, flush_d;
    logic             abort_q, abort_d;
    logic             ack_q, mtr_q;

    logic ack_fall, mtr_fall, ht_oor, take_rd_path;

    assign ack_fall = ack_q & ~sd_ack;
    assign mtr_fall = mtr_q & ~mtr;
    assign ht_oor   = ({25'd0, cur_ht_q} >= 32'(MAX_HTRACK));

    assign busy   = busy_q;
    assign sd_rd  = sd_rd_q;
    assign sd_wr  = sd_wr_q;
    assign sd_blk = blk_q;
    assign sd_lba = ({25'd0, htrack_l_q} * 32'(TRACK_BLOCKS)) + {28'd0, blk_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cur_ht_q   <= '0;
            htrack_l_q <= '0;
            cnt_q      <= '0;
            blk_q      <= '0;
            dirty_q    <= 1'b0;
            loaded_q   <= 1'b0;
            busy_q     <= 1'b0;
            sd_rd_q    <= 1'b0;
            sd_wr_q    <= 1'b0;
            flush_q    <= 1'b0;
            abort_q    <= 1'b0;
            ack_q      <= 1'b0;
            mtr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_ht_q   <= cur_ht_d;
            htrack_l_q <= htrack_l_d;
            cnt_q      <= cnt_d;
            blk_q      <= blk_d;
            dirty_q    <= dirty_d;
            loaded_q   <= loaded_d;
            busy_q     <= busy_d;
            sd_rd_q    <= sd_rd_d;
            sd_wr_q    <= sd_wr_d;
            flush_q    <= flush_d;
            abort_q    <= abort_d;
            ack_q      <= sd_ack;
            mtr_q      <= mtr;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_ht_d     = cur_ht_q;
        htrack_l_d   = htrack_l_q;
        cnt_d        = cnt_q;
        blk_d        = blk_q;
        dirty_d      = dirty_q;
        loaded_d     = loaded_q;
        busy_d       = busy_q;
        sd_rd_d      = sd_rd_q;
        sd_wr_d      = sd_wr_q;
        flush_d      = flush_q;
        abort_d      = abort_q;
        take_rd_path = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (gcr_we && loaded_q)
                    dirty_d = 1'b1;
                if (htrack != cur_ht_q || img_mounted) begin
                    if (img_mounted)
                        dirty_d = 1'b0;
                    cur_ht_d = htrack;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_SETTLE;
                end else if (mtr_fall && dirty_q && loaded_q && !img_readonly) begin
                    // Spindle stopped: flush the current track, no reload follows
                    blk_d   = '0;
                    sd_wr_d = 1'b1;
                    flush_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_WB_REQ;
                end
            end
            S_SETTLE: begin
                if (htrack != cur_ht_q) begin
                    cur_ht_d = htrack;
                    cnt_d    = '0;
                end else if (ce) begin
                    if (cnt_q == CNT_LAST) begin
                        if (dirty_q && loaded_q && !img_readonly) begin
                            blk_d   = '0;
                            sd_wr_d = 1'b1;
                            flush_d = 1'b0;
                            state_d = S_WB_REQ;
                        end else begin
                            take_rd_path = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WB_REQ: begin
                if (sd_ack) begin
                    sd_wr_d = 1'b0;
                    state_d = S_WB_XFER;
                end
            end
            S_WB_XFER: begin
                if (ack_fall) begin
                    if (blk_q == LAST_BLK) begin
                        dirty_d = 1'b0;
                        if (flush_q) begin
                            flush_d = 1'b0;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            take_rd_path = 1'b1;
                        end
                    end else begin
                        blk_d   = blk_q + 4'd1;
                        sd_wr_d = 1'b1;
                        state_d = S_WB_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                if (sd_ack) begin
                    sd_rd_d = 1'b0;
                    state_d = S_RD_XFER;
                end
            end
            S_RD_XFER: begin
                if (ack_fall) begin
                    if (blk_q == LAST_BLK) begin
                        loaded_d = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        blk_d   = blk_q + 4'd1;
                        sd_rd_d = 1'b1;
                        state_d = S_RD_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Shared by a clean settle exit and a finished write-back
        if (take_rd_path) begin
            dirty_d = 1'b0;
            if (ht_oor) begin
                loaded_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end else begin
                htrack_l_d = cur_ht_q;
                blk_d      = '0;
                loaded_d   = 1'b0;
                sd_rd_d    = 1'b1;
                state_d    = S_RD_REQ;
            end
        end

        // A new image mid-operation discards everything; an in-flight block must finish first
        if (state_q != S_IDLE && (img_mounted || abort_q)) begin
            dirty_d    = 1'b0;
            loaded_d   = 1'b0;
            sd_rd_d    = 1'b0;
            sd_wr_d    = 1'b0;
            busy_d     = 1'b1;
            flush_d    = 1'b0;
            blk_d      = blk_q;
            htrack_l_d = htrack_l_q;
            if (sd_ack) begin
                abort_d  = 1'b1;
                state_d  = state_q;
                cnt_d    = cnt_q;
                cur_ht_d = cur_ht_q;
            end else begin
                abort_d  = 1'b0;
                state_d  = S_SETTLE;
                cur_ht_d = htrack;
                cnt_d    = '0;
            end
        end
    end

endmodule
